// File: rtl/red_pitaya_asg_outstage_pkg.sv
// rtl/red_pitaya_asg_outstage_pkg.sv - shared widths, ramp state encoding and gain helpers
package red_pitaya_asg_outstage_pkg;

    localparam int OS_DW = 14;
    localparam int OS_GW = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    function automatic int gfull(input int gw);
        return 1 << gw;
    endfunction

endpackage

// File: rtl/red_pitaya_asg_outstage_if.sv
// rtl/red_pitaya_asg_outstage_if.sv - sample, control and status bundle of the output stage
interface red_pitaya_asg_outstage_if
    import red_pitaya_asg_outstage_pkg::*;
#(
    parameter int DW = OS_DW,
    parameter int GW = OS_GW
);
    logic signed [DW-1:0] dat_i;
    logic                 en_i;
    logic        [GW-1:0] set_rstep_i;
    logic        [DW-1:0] set_slew_i;
    logic signed [DW-1:0] dac_o;
    logic           [1:0] state_o;
    logic                 busy_o;
    logic                 ramp_done_o;

    modport slave (
        input  dat_i, en_i, set_rstep_i, set_slew_i,
        output dac_o, state_o, busy_o, ramp_done_o
    );

    modport master (
        output dat_i, en_i, set_rstep_i, set_slew_i,
        input  dac_o, state_o, busy_o, ramp_done_o
    );
endinterface

// File: rtl/red_pitaya_slew_lim.sv
// rtl/red_pitaya_slew_lim.sv - registered per-cycle slew-rate limiter (limit 0 = pass through)
module red_pitaya_slew_lim #(
    parameter int DW = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic signed [DW-1:0] i_target,
    input  logic        [DW-1:0] i_limit,
    output logic signed [DW-1:0] o_dat
);
    logic signed [DW-1:0] r_dat;
    logic signed [DW:0]   w_d;
    logic        [DW:0]   w_mag;
    logic signed [DW:0]   w_step;
    logic signed [DW:0]   w_sum;
    logic                 w_clip;
    logic signed [DW-1:0] w_nxt;

    // One extra bit keeps the difference of two full-scale samples exact.
    always_comb begin
        w_d    = (DW+1)'(i_target) - (DW+1)'(r_dat);
        w_mag  = w_d[DW] ? $unsigned(-w_d) : $unsigned(w_d);
        w_clip = (i_limit != '0) && (w_mag > {1'b0, i_limit});
        w_step = w_d[DW] ? -$signed({1'b0, i_limit}) : $signed({1'b0, i_limit});
        w_sum  = (DW+1)'(r_dat) + w_step;
        w_nxt  = w_clip ? DW'(w_sum) : i_target;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_dat <= '0;
        else       r_dat <= w_nxt;
    end

    assign o_dat = r_dat;
endmodule

// File: rtl/red_pitaya_asg_outstage.sv
// rtl/red_pitaya_asg_outstage.sv - soft-start/stop gain ramp, gain multiply and slew limit per ASG channel
module red_pitaya_asg_outstage
    import red_pitaya_asg_outstage_pkg::*;
#(
    parameter int DW = OS_DW,
    parameter int GW = OS_GW
) (
    input  logic                      dac_clk_i,
    input  logic                      dac_rst_i,
    red_pitaya_asg_outstage_if.slave  bus
);
    localparam int            GFULL_I = gfull(GW);
    localparam logic [GW:0]   GFULL   = GFULL_I[GW:0];
    localparam int            PW      = DW + GW + 2;

    state_t               r_state, w_state_nxt;
    logic        [GW:0]   r_g, w_g_nxt, w_g_up, w_g_dn;
    logic        [GW+1:0] w_g_sum;
    logic                 r_busy, r_done, w_done_nxt;
    logic signed [DW-1:0] r_dat, r_scl, w_scl, w_dac;
    logic signed [PW-1:0] w_prod;

    // Saturating gain steps; a zero step jumps straight to the endpoint.
    always_comb begin
        w_g_sum = {1'b0, r_g} + {2'b00, bus.set_rstep_i};
        if (bus.set_rstep_i == '0 || w_g_sum >= {1'b0, GFULL}) w_g_up = GFULL;
        else                                                     w_g_up = w_g_sum[GW:0];
        if (bus.set_rstep_i == '0 || {1'b0, bus.set_rstep_i} >= r_g) w_g_dn = '0;
        else                                                          w_g_dn = r_g - {1'b0, bus.set_rstep_i};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_OFF: if (bus.en_i) w_state_nxt = ST_UP;
            ST_UP: begin
                if (!bus.en_i) begin
                    w_state_nxt = ST_DOWN;
                end else begin
                    w_g_nxt = w_g_up;
                    if (w_g_up == GFULL) begin
                        w_state_nxt = ST_ON;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_ON: if (!bus.en_i) w_state_nxt = ST_DOWN;
            ST_DOWN: begin
                if (bus.en_i) begin
                    w_state_nxt = ST_UP;
                end else begin
                    w_g_nxt = w_g_dn;
                    if (w_g_dn == '0) begin
                        w_state_nxt = ST_OFF;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            r_state <= ST_OFF;
            r_g     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
            r_busy  <= (w_state_nxt == ST_UP) || (w_state_nxt == ST_DOWN);
            r_done  <= w_done_nxt;
        end
    end

    // Arithmetic shift of the exact product gives floor rounding; g <= GFULL keeps it in range.
    always_comb begin
        w_prod = PW'(r_dat) * PW'($signed({1'b0, r_g}));
        w_scl  = DW'(w_prod >>> GW);
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            r_dat <= '0;
            r_scl <= '0;
        end else begin
            r_dat <= bus.dat_i;
            r_scl <= w_scl;
        end
    end

    red_pitaya_slew_lim #(.DW(DW)) u_slew (
        .i_clk    (dac_clk_i),
        .i_rst    (dac_rst_i),
        .i_target (r_scl),
        .i_limit  (bus.set_slew_i),
        .o_dat    (w_dac)
    );

    assign bus.dac_o       = w_dac;
    assign bus.state_o     = r_state;
    assign bus.busy_o      = r_busy;
    assign bus.ramp_done_o = r_done;
endmodule

// File: tb/tb_red_pitaya_asg_outstage.sv
// tb/tb_red_pitaya_asg_outstage.sv - directed and randomized checks of the output stage against a reference model
module tb_red_pitaya_asg_outstage;
    localparam int DW = 14;
    localparam int GW = 16;
    localparam int GF = 65536;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    red_pitaya_asg_outstage_if #(.DW(DW), .GW(GW)) bus();
    red_pitaya_asg_outstage #(.DW(DW), .GW(GW)) dut (
        .dac_clk_i (clk),
        .dac_rst_i (rst),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int in_dat, in_en, in_rstep, in_slew;
    int m_state, m_g, m_datr, m_scl, m_dac, m_busy, m_done;
    int done_cnt;

    function automatic int floor_div(input longint p);
        if (p >= 0) return int'(p / GF);
        return int'(-((-p + GF - 1) / GF));
    endfunction

    function automatic int slew_fn(input int tgt, input int cur, input int lim);
        int d;
        d = tgt - cur;
        if (lim != 0 && (d > lim || d < -lim)) return (d > 0) ? cur + lim : cur - lim;
        return tgt;
    endfunction

    task automatic model_reset();
        m_state = 0; m_g = 0; m_datr = 0; m_scl = 0; m_dac = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_clock();
        int n_state, n_g, n_done;
        n_state = m_state; n_g = m_g; n_done = 0;
        case (m_state)
            0: if (in_en != 0) n_state = 1;
            1: if (in_en == 0) n_state = 3;
               else begin
                   n_g = (in_rstep == 0) ? GF : ((m_g + in_rstep > GF) ? GF : m_g + in_rstep);
                   if (n_g == GF) begin n_state = 2; n_done = 1; end
               end
            2: if (in_en == 0) n_state = 3;
            default: if (in_en != 0) n_state = 1;
               else begin
                   n_g = (in_rstep == 0) ? 0 : ((m_g - in_rstep < 0) ? 0 : m_g - in_rstep);
                   if (n_g == 0) begin n_state = 0; n_done = 1; end
               end
        endcase
        m_dac   = slew_fn(m_scl, m_dac, in_slew);
        m_scl   = floor_div(longint'(m_datr) * m_g);
        m_datr  = in_dat;
        m_state = n_state;
        m_g     = n_g;
        m_done  = n_done;
        m_busy  = (n_state == 1 || n_state == 3) ? 1 : 0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input int e, input int r, input int s);
        in_dat = d; in_en = e; in_rstep = r; in_slew = s;
        bus.dat_i       = 14'(d);
        bus.en_i        = (e != 0);
        bus.set_rstep_i = 16'(r);
        bus.set_slew_i  = 14'(s);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_clock();
        #1;
        chk("dac",   int'(bus.dac_o), m_dac);
        chk("state", int'(bus.state_o), m_state);
        chk("busy",  int'(bus.busy_o), m_busy);
        chk("done",  int'(bus.ramp_done_o), m_done);
        if (bus.ramp_done_o) done_cnt++;
    endtask

    function automatic int dac_now();
        return int'(bus.dac_o);
    endfunction

    initial begin
        int prev, cur, n, bad, cnt, maxd, mono;
        model_reset();
        done_cnt = 0;
        drive(32'h1000, 1, 0, 0);

        // reset held with en_i=1
        repeat (3) step();
        chk("rst_dac", dac_now(), 0);
        chk("rst_state", int'(bus.state_o), 0);
        rst = 1'b0;
        repeat (3) step();
        chk("tp1_dac_c3", dac_now(), 0);
        step();
        chk("tp1_dac_c4", dac_now(), 32'h1000);
        repeat (4) step();
        chk("tp1_pulses", done_cnt, 1);

        // full ramp up/down with step 0x1000
        drive(8191, 0, 0, 0);
        repeat (6) step();
        chk("tp2_off", int'(bus.state_o), 0);
        drive(8191, 1, 32'h1000, 0);
        done_cnt = 0; cnt = 0; mono = 1; prev = dac_now();
        repeat (24) begin
            step();
            if (bus.state_o == 2'd1) cnt++;
            if (dac_now() < prev) mono = 0;
            prev = dac_now();
        end
        chk("tp2_up_cycles", cnt, 16);
        chk("tp2_up_mono", mono, 1);
        chk("tp2_up_final", dac_now(), 8191);
        chk("tp2_up_pulses", done_cnt, 1);
        drive(8191, 0, 32'h1000, 0);
        done_cnt = 0; cnt = 0; mono = 1; prev = dac_now();
        repeat (24) begin
            step();
            if (bus.state_o == 2'd3) cnt++;
            if (dac_now() > prev) mono = 0;
            prev = dac_now();
        end
        chk("tp2_dn_cycles", cnt, 16);
        chk("tp2_dn_mono", mono, 1);
        chk("tp2_dn_final", dac_now(), 0);
        chk("tp2_dn_state", int'(bus.state_o), 0);
        chk("tp2_dn_pulses", done_cnt, 1);

        // slew-limited full-scale step
        drive(-8192, 1, 0, 0);
        repeat (8) step();
        chk("negfs_full", dac_now(), -8192);
        drive(8191, 1, 0, 100);
        n = 0; bad = 0; prev = dac_now();
        repeat (200) begin
            step();
            cur = dac_now();
            if (cur != prev) begin
                n++;
                if (!((cur - prev == 100) || (cur == 8191 && cur - prev == 83))) bad++;
            end
            prev = cur;
        end
        chk("slew_cycles", n, 164);
        chk("slew_bad_steps", bad, 0);
        chk("slew_final", dac_now(), 8191);

        // reversal mid-ramp
        drive(8000, 0, 0, 0);
        repeat (6) step();
        drive(8000, 1, 32'h800, 0);
        cnt = 0;
        while (!(m_state == 1 && m_g == 32'h8000) && cnt < 40) begin step(); cnt++; end
        chk("rev_reach_half", m_g, 32'h8000);
        drive(8000, 0, 32'h800, 0);
        step();
        chk("rev_state", int'(bus.state_o), 3);
        maxd = 0; prev = dac_now();
        repeat (40) begin
            step();
            cur = dac_now();
            if (cur - prev > maxd) maxd = cur - prev;
            if (prev - cur > maxd) maxd = prev - cur;
            prev = cur;
        end
        chk("rev_smooth", (maxd <= 251) ? 1 : 0, 1);
        chk("rev_end_off", int'(bus.state_o), 0);

        // asynchronous reset mid-UP
        drive(8000, 1, 32'h800, 0);
        cnt = 0;
        while (m_dac < 4000 && cnt < 40) begin step(); cnt++; end
        chk("arst_pre_dac_high", (dac_now() >= 4000) ? 1 : 0, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_dac", dac_now(), 0);
        chk("arst_state", int'(bus.state_o), 0);
        chk("arst_busy", int'(bus.busy_o), 0);
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("arst_release_up", int'(bus.state_o), 1);

        // hold g at half gain by alternating the enable against the state
        drive(-8192, 1, 32'h8000, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(-8192, i % 2, 32'h8000, 0);
            step();
        end
        chk("half_negfs", dac_now(), -4096);
        for (int i = 0; i < 8; i++) begin
            drive(-1, i % 2, 32'h8000, 0);
            step();
        end
        chk("half_minus1", dac_now(), -1);

        // randomized traffic
        drive(0, 1, 32'h400, 0);
        for (int i = 0; i < 600; i++) begin
            int e, r, s;
            e = in_en; r = in_rstep; s = in_slew;
            if ($urandom_range(0, 15) == 0) e = 1 - e;
            if (i % 32 == 0) begin
                case ($urandom_range(0, 2))
                    0: r = 0;
                    1: r = int'($urandom_range(1, 32'h3000));
                    default: r = int'($urandom_range(32'h3000, 32'hFFFF));
                endcase
                s = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3000));
            end
            drive(int'($urandom_range(0, 16383)) - 8192, e, r, s);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
